conv2_maxpool: RTL and testbench

2x2 stride-2 signed max-pool stage placed directly downstream of the conv2 activation/requantize stage.
- Consumes the int8 activation stream of one conv2 output channel in raster order (row-major, one pixel per accepted beat).
- Emits one int8 pooled value per 2x2 window, with valid/ready handshakes on both sides.
- Holds half-row partial maxima in an internal line buffer so the input stream is never stored whole.

---
 rtl/conv2_maxpool_pkg.sv | 38 +++
 rtl/conv2_maxpool_if.sv | 56 +++++
 rtl/conv2_pool_linebuf.sv | 39 +++
 rtl/conv2_maxpool.sv | 156 +++++++++++++++
 tb/tb_conv2_maxpool.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/conv2_maxpool_pkg.sv
// ---------------------------------------------------------------------------
// conv2_maxpool_pkg
//   Shared conv2 constants and helpers for the conv2 max-pool stage.
//   - CONV2_ACT_W  : activation width coming out of the conv2 requantizer
//   - CONV2_OUT_W/H: conv2 output feature-map dimensions (pool defaults)
//   - smax()       : signed maximum on a wide signed operand; callers
//                    sign-extend into it and truncate the result back, so
//                    -128/127 extremes never overflow.
//   - beat_kind_e  : what an accepted input beat does inside the pool stage.
// ---------------------------------------------------------------------------
package conv2_maxpool_pkg;

  localparam int CONV2_ACT_W = 8;
  localparam int CONV2_OUT_W = 8;
  localparam int CONV2_OUT_H = 8;

  // Width of the operands smax() works on. Any DATA_W up to this fits.
  localparam int SMAX_W = 32;

  // Role of a beat, decided by its (row, col) parity:
  //   BEAT_HOLD : even column, pixel is parked in the held register
  //   BEAT_PAIR : even row, odd column, horizontal pair max goes to linebuf
  //   BEAT_POOL : odd row, odd column, completes a 2x2 window
  typedef enum logic [1:0] {
    BEAT_HOLD = 2'd0,
    BEAT_PAIR = 2'd1,
    BEAT_POOL = 2'd2
  } beat_kind_e;

  // Signed maximum. Ties return b; the value is identical either way.
  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conv2_maxpool_if.sv
// ---------------------------------------------------------------------------
// conv2_maxpool_if
//   Handshake bundle of the conv2 max-pool stage: the activation input
//   stream and the pooled output stream.
//
//   Valid/ready semantics (both streams): a beat transfers on a rising clock
//   edge where valid && ready are both 1. A producer holding valid keeps its
//   data (and last) stable until the transfer; ready may depend
//   combinationally on the consumer's own state but never on valid.
//
//   Signals
//     in_valid  : upstream activation valid
//     in_ready  : pool stage can accept in_data this cycle
//     in_data   : signed activation, raster order
//     out_valid : pooled value valid
//     out_ready : downstream accepts out_data
//     out_data  : signed pooled max
//     out_last  : marks the final pooled value of a frame
//
//   Modports
//     master : the environment around the stage (drives inputs, out_ready)
//     slave  : the pool stage itself
// ---------------------------------------------------------------------------
interface conv2_maxpool_if #(
  parameter int DATA_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last
  );

endinterface

// File: rtl/conv2_pool_linebuf.sv
// ---------------------------------------------------------------------------
// conv2_pool_linebuf
//   Register-array line buffer holding one half-row of horizontal pair
//   maxima. Synchronous write, asynchronous (same-cycle) read. The data
//   array has no reset: every entry is written on an even row before the
//   following odd row reads it.
//
//   Ports
//     clk   : clock
//     we    : write enable
//     waddr : write index (0..DEPTH-1)
//     wdata : value to store
//     raddr : read index (0..DEPTH-1)
//     rdata : stored value at raddr, combinational
// ---------------------------------------------------------------------------
module conv2_pool_linebuf #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int AW     = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/conv2_maxpool.sv
// ---------------------------------------------------------------------------
// conv2_maxpool
//   2x2 stride-2 signed max-pool for one conv2 output channel. Takes the
//   activation stream in raster order, one pixel per accepted beat, and
//   emits one pooled value per 2x2 window with a one-cycle latency from the
//   beat that completes the window.
//
//   Datapath per accepted beat:
//     even col            : pixel -> held register
//     even row, odd col   : smax(held, pixel) -> linebuf[col/2]
//     odd row,  odd col   : smax(linebuf[col/2], smax(held, pixel))
//                           -> output register
//
//   Ports
//     clk   : clock
//     rst_n : asynchronous active-low reset
//     bus   : conv2_maxpool_if.slave (input stream + pooled output stream)
//
//   in_ready = !out_valid || out_ready, so the stage only stalls when the
//   single output register is occupied and not draining; a drain and a
//   reload in the same cycle keep full throughput.
// ---------------------------------------------------------------------------
module conv2_maxpool
  import conv2_maxpool_pkg::*;
#(
  parameter int DATA_W = CONV2_ACT_W,
  parameter int IMG_W  = CONV2_OUT_W,
  parameter int IMG_H  = CONV2_OUT_H
) (
  input logic           clk,
  input logic           rst_n,
  conv2_maxpool_if.slave bus
);

  localparam int HALF_W = IMG_W / 2;
  localparam int CW     = (IMG_W > 1)  ? $clog2(IMG_W)  : 1;
  localparam int RW     = (IMG_H > 1)  ? $clog2(IMG_H)  : 1;
  localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  // Frame geometry must tile exactly into 2x2 windows.
  generate
    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_dims
      $error("conv2_maxpool: IMG_W and IMG_H must be even and >= 2");
    end
    if (DATA_W > SMAX_W || DATA_W < 2) begin : g_bad_width
      $error("conv2_maxpool: DATA_W out of range for smax");
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Position and beat classification
  // -------------------------------------------------------------------------
  logic [CW-1:0]            col;
  logic [RW-1:0]            row;
  logic signed [DATA_W-1:0] held;
  logic signed [DATA_W-1:0] pix;
  logic                     accept;
  beat_kind_e               kind;

  assign pix          = bus.in_data;
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    kind = BEAT_HOLD;
    if (col[0]) begin
      kind = row[0] ? BEAT_POOL : BEAT_PAIR;
    end
  end

  // Raster counters: col wraps into row, row wraps into the next frame with
  // no gap cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Left pixel of the current horizontal pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held <= '0;
    end else if (accept && kind == BEAT_HOLD) begin
      held <= pix;
    end
  end

  // -------------------------------------------------------------------------
  // Pair max, line buffer and window max
  // -------------------------------------------------------------------------
  logic signed [DATA_W-1:0] pair_max;
  logic signed [DATA_W-1:0] lb_top;
  logic [DATA_W-1:0]        lb_rdata;
  logic signed [DATA_W-1:0] pool_result;
  logic [AW-1:0]            lb_addr;
  logic                     lb_we;
  logic                     load;
  logic                     frame_end;

  // Operands are sign-extended into smax's wide type, so the truncation back
  // to DATA_W is lossless (the max of two DATA_W values fits in DATA_W).
  assign pair_max    = DATA_W'(smax(SMAX_W'(held), SMAX_W'(pix)));
  assign lb_top      = lb_rdata;
  assign pool_result = DATA_W'(smax(SMAX_W'(lb_top), SMAX_W'(pair_max)));

  // Write and read share the index: col/2 names the window column both on
  // the even row that fills it and the odd row that consumes it.
  assign lb_addr   = AW'(col >> 1);
  assign lb_we     = accept && (kind == BEAT_PAIR);
  assign load      = accept && (kind == BEAT_POOL);
  assign frame_end = (row == ROW_LAST) && (col == COL_LAST);

  conv2_pool_linebuf #(
    .DEPTH  (HALF_W),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_linebuf (
    .clk   (clk),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (pair_max),
    .raddr (lb_addr),
    .rdata (lb_rdata)
  );

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  // A load wins over a drain: when the old value leaves and a new window
  // completes on the same edge, the new value replaces it and valid stays 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
    end else if (load) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= pool_result;
      bus.out_last  <= frame_end;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv2_maxpool.sv
// ---------------------------------------------------------------------------
// tb_conv2_maxpool
//   Self-checking bench for conv2_maxpool on a 4x4 frame. A frame-level
//   reference model computes every 2x2 window maximum from the whole frame
//   and queues the expected pooled values; a monitor compares each output
//   handshake against that queue.
// ---------------------------------------------------------------------------
module tb_conv2_maxpool;
  import conv2_maxpool_pkg::*;

  localparam int DW   = 8;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  conv2_maxpool_if #(.DATA_W(DW)) bus ();

  conv2_maxpool #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // out_ready is either fixed by the main sequence or randomized per cycle.
  logic fixed_ready = 1'b1;
  logic rnd_ready   = 1'b1;
  logic rand_ready  = 1'b0;

  assign bus.out_ready = rand_ready ? rnd_ready : fixed_ready;

  always @(posedge clk) begin
    #1;
    rnd_ready = ($urandom_range(0, 1) == 1);
  end

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_last   = 0;
  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: max over each 2x2 window of the full frame, raster order.
  task automatic model_frame(input logic [DW-1:0] f[NPIX]);
    for (int pr = 0; pr < H / 2; pr++) begin
      for (int pc = 0; pc < W / 2; pc++) begin
        int m;
        m = -100000;
        for (int dr = 0; dr < 2; dr++) begin
          for (int dc = 0; dc < 2; dc++) begin
            logic signed [DW-1:0] sv;
            int v;
            sv = f[(2 * pr + dr) * W + 2 * pc + dc];
            v  = sv;
            if (v > m) m = v;
          end
        end
        exp_q.push_back(DW'(m));
        exp_last_q.push_back((pr == H / 2 - 1) && (pc == W / 2 - 1));
      end
    end
  endtask

  // Output monitor: one comparison set per output handshake.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check("exp_q_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        check("out_data", bus.out_data, exp_q.pop_front());
        check("out_last", bus.out_last, exp_last_q.pop_front());
      end
      if (bus.out_last) n_last++;
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic send_beat(input logic [DW-1:0] d, input bit gaps);
    logic ok;
    if (gaps) begin
      while ($urandom_range(0, 1) == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = DW'($urandom);
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      if (t > 1000) begin
        check("accept_timeout", ok, 1);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] f[NPIX], input bit gaps);
    for (int i = 0; i < NPIX; i++) send_beat(f[i], gaps);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 500 && exp_q.size() > 0; t++) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 0);
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  int            ia[NPIX] = '{1, -5, 3, 2,
                              4, 0, -1, 7,
                              -128, -128, -128, -128,
                              -128, -100, 127, -128};
  logic [DW-1:0] fa[NPIX];
  logic [DW-1:0] fr[NPIX];

  initial begin
    int last0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    for (int i = 0; i < NPIX; i++) fa[i] = DW'(ia[i]);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed frame, out_ready=1: latency and producing-beat pattern
    model_frame(fa);
    for (int i = 0; i < NPIX; i++) begin
      bit produce;
      send_beat(fa[i], 1'b0);
      produce = ((i / W) % 2 == 1) && ((i % W) % 2 == 1);
      check("lat_valid", bus.out_valid, produce);
      if (produce) begin
        check("lat_data", bus.out_data, exp_q[0]);
        check("lat_last", bus.out_last, i == NPIX - 1);
      end
    end
    wait_drain();

    // Backpressure on the first pooled value
    model_frame(fa);
    fixed_ready = 1'b0;
    for (int i = 0; i < 6; i++) send_beat(fa[i], 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = fa[6];
    repeat (4) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", bus.out_data, exp_q[0]);
      check("bp_in_ready", bus.in_ready, 0);
    end
    @(posedge clk);
    #1;
    fixed_ready = 1'b1;
    for (int i = 6; i < NPIX; i++) send_beat(fa[i], 1'b0);
    wait_drain();

    // Back-to-back frames, no idle cycles
    last0 = n_last;
    model_frame(fa);
    model_frame(fa);
    send_frame(fa, 1'b0);
    send_frame(fa, 1'b0);
    wait_drain();
    check("last_per_frame", n_last - last0, 2);

    // Reset after 6 beats, then the full frame again
    for (int i = 0; i < 6; i++) send_beat(fa[i], 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_last", bus.out_last, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_frame(fa);
    send_frame(fa, 1'b0);
    wait_drain();

    // Random frames with random in_valid gaps and out_ready toggling
    rand_ready = 1'b1;
    last0 = n_last;
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < NPIX; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          fr[i] = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h7F;
        end else begin
          fr[i] = DW'($urandom);
        end
      end
      model_frame(fr);
      send_frame(fr, 1'b1);
    end
    wait_drain();
    rand_ready = 1'b0;
    check("rand_last_count", n_last - last0, 100);
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #600000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time bound exceeded");
  end

endmodule
